// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: EX operand forwarding, load-use stall, multi-cycle MDU
// stall FSM, taken-branch flush and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mdu_start,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // mcnt holds the number of BUSY cycles still to come after the current one
    localparam int MCW = (MDU_LAT > 3) ? $clog2(MDU_LAT - 2) : 1;
    localparam logic [MCW-1:0] MCNT_INIT = MCW'((MDU_LAT >= 3) ? (MDU_LAT - 3) : 0);

    logic [1:0]       state_q, state_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mdu_stall, load_use, br_flush, lu_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == rs))      return 2'b10;
        else if (w_we && (w_rd != '0) && (w_rd == rs)) return 2'b01;
        else                                           return 2'b00;
    endfunction

    always_comb begin
        state_d   = state_q;
        mcnt_d    = mcnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_mdu_start && (MDU_LAT > 1)) begin
                    mdu_stall = 1'b1;
                    if (MDU_LAT == 2) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        mcnt_d  = MCNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                mdu_stall = 1'b1;
                if (mcnt_q == '0) state_d = ST_DONE;
                else              mcnt_d  = mcnt_q - 1'b1;
            end
            // the op leaves EX this cycle; its start flag is still visible and ignored
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));
        br_flush = branch_taken && !mdu_stall;
        lu_stall = load_use && !mdu_stall && !branch_taken;

        forward_a     = rstn ? fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;
        forward_b     = rstn ? fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;
        pc_stall      = rstn && (mdu_stall || lu_stall);
        if_id_stall   = rstn && (mdu_stall || lu_stall);
        if_id_flush   = rstn && br_flush;
        id_ex_stall   = rstn && mdu_stall;
        id_ex_bubble  = rstn && (br_flush || lu_stall);
        ex_mem_bubble = rstn && mdu_stall;
        mdu_busy      = rstn && mdu_stall;

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three instances (default, MDU_LAT=1, CNT_W=4)
// share stimulus and are checked against a stall-count reference model.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mdu_start, branch_taken;
    logic       mem_reg_write, wb_reg_write;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
    logic        a_pc, a_ifs, a_iff, a_ides, a_idb, a_exb, a_busy;
    logic        b_pc, b_ifs, b_iff, b_ides, b_idb, b_exb, b_busy;
    logic        c_pc, c_ifs, c_iff, c_ides, c_idb, c_exb, c_busy;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_control_unit u_a (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .branch_taken(branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .forward_a(a_fa), .forward_b(a_fb), .pc_stall(a_pc), .if_id_stall(a_ifs),
        .if_id_flush(a_iff), .id_ex_stall(a_ides), .id_ex_bubble(a_idb),
        .ex_mem_bubble(a_exb), .mdu_busy(a_busy), .stall_cycles(a_cnt));

    hazard_control_unit #(.MDU_LAT(1)) u_b (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .branch_taken(branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .forward_a(b_fa), .forward_b(b_fb), .pc_stall(b_pc), .if_id_stall(b_ifs),
        .if_id_flush(b_iff), .id_ex_stall(b_ides), .id_ex_bubble(b_idb),
        .ex_mem_bubble(b_exb), .mdu_busy(b_busy), .stall_cycles(b_cnt));

    hazard_control_unit #(.CNT_W(4)) u_c (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .branch_taken(branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .forward_a(c_fa), .forward_b(c_fb), .pc_stall(c_pc), .if_id_stall(c_ifs),
        .if_id_flush(c_iff), .id_ex_stall(c_ides), .id_ex_bubble(c_idb),
        .ex_mem_bubble(c_exb), .mdu_busy(c_busy), .stall_cycles(c_cnt));

    // Reference model: each instance tracks how many MDU stall cycles remain and
    // whether the op is in its final non-stalled EX cycle.
    int  lat[3]  = '{4, 1, 4};
    int  cmax[3] = '{65535, 65535, 15};
    int  m_left[3];
    bit  m_done[3];
    int  m_cnt[3];
    bit  e_pc[3], e_busy[3];
    logic [1:0] e_fa, e_fb;
    logic e_ifs, e_iff, e_ides, e_idb, e_exb;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_eval();
        bit lu, ms;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        for (int k = 0; k < 3; k++) begin
            ms = (m_left[k] > 0) || (!m_done[k] && ex_mdu_start && lat[k] > 1);
            e_busy[k] = rstn && ms;
            e_pc[k]   = rstn && (ms || (lu && !branch_taken));
        end
        ms     = e_busy[0];
        e_fa   = rstn ? fwd(ex_rs1) : 2'b00;
        e_fb   = rstn ? fwd(ex_rs2) : 2'b00;
        e_ifs  = e_pc[0];
        e_iff  = rstn && branch_taken && !ms;
        e_ides = ms;
        e_idb  = rstn && !ms && (branch_taken || lu);
        e_exb  = ms;
    endtask

    task automatic model_tick();
        for (int k = 0; k < 3; k++) begin
            if (e_pc[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) m_done[k] = 1;
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (ex_mdu_start && lat[k] > 1) begin
                m_left[k] = lat[k] - 2;
                if (m_left[k] == 0) m_done[k] = 1;
            end
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic adv();
        model_eval();
        @(posedge clk);
        if (rstn) model_tick();
        #1;
    endtask

    task automatic clr_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_mdu_start = 0;
        branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic set_hits();
        ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; branch_taken = 1;
    endtask

    task automatic do_reset();
        rstn = 0;
        #1;
        @(posedge clk);
        #1;
        rstn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        set_hits();
        ex_mdu_start = 1;
        #1;
        tests++;
        if ({a_fa, a_fb, a_pc, a_ifs, a_iff, a_ides, a_idb, a_exb, a_busy, a_cnt, c_cnt, b_pc} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got fa=%b fb=%b pc=%b iff=%b idb=%b busy=%b cnt=%0d, want all 0",
                     a_fa, a_fb, a_pc, a_iff, a_idb, a_busy, a_cnt);
        end
        clr_inputs();
        do_reset();
    endtask

    task automatic test_forwarding();
        clr_inputs();
        ex_rs1 = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
        settle();
        tests++;
        if (a_fa !== 2'b10) begin fails++; $display("FAIL fwd_mem_prio: got %b want 10", a_fa); end
        mem_rd = 0;
        settle();
        tests++;
        if (a_fa !== 2'b01) begin fails++; $display("FAIL fwd_wb_past_x0: got %b want 01", a_fa); end
        ex_rs2 = 0; wb_rd = 0;
        settle();
        tests++;
        if (a_fb !== 2'b00) begin fails++; $display("FAIL fwd_x0: got %b want 00", a_fb); end
        ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 4; mem_reg_write = 0;
        settle();
        tests++;
        if ({a_fa, a_fb} !== 4'b0000) begin fails++; $display("FAIL fwd_we_off: got %b want 0000", {a_fa, a_fb}); end
        adv();
    endtask

    task automatic test_load_use();
        clr_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        settle();
        tests++;
        if ({a_pc, a_ifs, a_idb, a_ides, a_busy} !== 5'b11100) begin
            fails++; $display("FAIL load_use_stall: got %b want 11100", {a_pc, a_ifs, a_idb, a_ides, a_busy});
        end
        tests++;
        if (a_cnt !== 16'd0) begin fails++; $display("FAIL load_use_cnt_before: got %0d want 0", a_cnt); end
        adv();
        id_uses_rs2 = 0;
        settle();
        tests++;
        if (a_cnt !== 16'd1) begin fails++; $display("FAIL load_use_cnt_after: got %0d want 1", a_cnt); end
        tests++;
        if ({a_pc, a_ifs, a_idb} !== 3'b000) begin
            fails++; $display("FAIL load_use_unused_rs2: got %b want 000", {a_pc, a_ifs, a_idb});
        end
        adv();
    endtask

    task automatic test_mdu();
        logic exp;
        clr_inputs();
        do_reset();
        ex_mdu_start = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            exp = (i < 3);
            tests++;
            if ({a_busy, a_pc, a_ifs, a_ides, a_exb, a_idb} !== {exp, exp, exp, exp, exp, 1'b0}) begin
                fails++;
                $display("FAIL mdu_cycle%0d: got busy/pc/ifs/ides/exb/idb=%b want %b", i + 1,
                         {a_busy, a_pc, a_ifs, a_ides, a_exb, a_idb}, {exp, exp, exp, exp, exp, 1'b0});
            end
            tests++;
            if ({b_busy, b_pc} !== 2'b00) begin fails++; $display("FAIL mdu_lat1_cycle%0d: got %b want 00", i + 1, {b_busy, b_pc}); end
            adv();
        end
        ex_mdu_start = 0;
        settle();
        tests++;
        if (a_cnt !== 16'd3) begin fails++; $display("FAIL mdu_stall_count: got %0d want 3", a_cnt); end
        tests++;
        if (b_cnt !== 16'd0) begin fails++; $display("FAIL mdu_lat1_count: got %0d want 0", b_cnt); end
        adv();
    endtask

    task automatic test_branch();
        clr_inputs();
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; branch_taken = 1;
        settle();
        tests++;
        if ({a_iff, a_idb, a_pc, a_ifs} !== 4'b1100) begin
            fails++; $display("FAIL branch_over_load_use: got iff/idb/pc/ifs=%b want 1100", {a_iff, a_idb, a_pc, a_ifs});
        end
        adv();
        clr_inputs();
        ex_mdu_start = 1;
        settle();
        adv();
        branch_taken = 1;
        settle();
        tests++;
        if ({a_iff, a_idb, a_busy, a_pc} !== 4'b0011) begin
            fails++; $display("FAIL branch_in_busy: got iff/idb/busy/pc=%b want 0011", {a_iff, a_idb, a_busy, a_pc});
        end
        for (int i = 0; i < 4; i++) adv();
        clr_inputs();
    endtask

    task automatic test_reset_mid_busy();
        clr_inputs();
        ex_mdu_start = 1;
        settle();
        adv();
        settle();
        tests++;
        if (a_busy !== 1'b1) begin fails++; $display("FAIL busy_before_reset: got %b want 1", a_busy); end
        set_hits();
        rstn = 0;
        #1;
        tests++;
        if ({a_fa, a_fb, a_pc, a_ifs, a_iff, a_ides, a_idb, a_exb, a_busy, a_cnt} !== '0) begin
            fails++; $display("FAIL reset_mid_busy: got fa=%b pc=%b busy=%b iff=%b cnt=%0d want all 0",
                              a_fa, a_pc, a_busy, a_iff, a_cnt);
        end
        @(posedge clk);
        #1;
        clr_inputs();
        rstn = 1;
        model_reset();
        settle();
        tests++;
        if ({a_busy, a_pc, a_exb, a_cnt} !== '0) begin
            fails++; $display("FAIL after_reset_release: got busy=%b pc=%b cnt=%0d want 0", a_busy, a_pc, a_cnt);
        end
        adv();
        settle();
        tests++;
        if ({a_busy, a_pc} !== 2'b00) begin fails++; $display("FAIL residual_stall: got %b want 00", {a_busy, a_pc}); end
        adv();
    endtask

    task automatic test_saturation();
        clr_inputs();
        do_reset();
        ex_mem_read = 1; ex_rd = 2; id_rs1 = 2; id_uses_rs1 = 1;
        for (int i = 0; i < 20; i++) adv();
        clr_inputs();
        settle();
        tests++;
        if (c_cnt !== 4'd15) begin fails++; $display("FAIL cnt_saturate: got %0d want 15", c_cnt); end
        tests++;
        if (a_cnt !== 16'd20) begin fails++; $display("FAIL cnt_wide: got %0d want 20", a_cnt); end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            ex_mdu_start = ($urandom_range(0, 4) == 0);
            settle();
            tests++;
            if ({a_fa, a_fb, a_pc, a_ifs, a_iff, a_ides, a_idb, a_exb, a_busy} !==
                {e_fa, e_fb, e_pc[0], e_ifs, e_iff, e_ides, e_idb, e_exb, e_busy[0]}) begin
                fails++;
                $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                         {a_fa, a_fb, a_pc, a_ifs, a_iff, a_ides, a_idb, a_exb, a_busy},
                         {e_fa, e_fb, e_pc[0], e_ifs, e_iff, e_ides, e_idb, e_exb, e_busy[0]});
            end
            tests++;
            if ({b_pc, b_busy, c_pc, c_busy} !== {e_pc[1], e_busy[1], e_pc[2], e_busy[2]}) begin
                fails++; $display("FAIL rand_variants[%0d]: got %b want %b", i, {b_pc, b_busy, c_pc, c_busy},
                                  {e_pc[1], e_busy[1], e_pc[2], e_busy[2]});
            end
            tests++;
            if (a_cnt !== 16'(m_cnt[0]) || b_cnt !== 16'(m_cnt[1]) || c_cnt !== 4'(m_cnt[2])) begin
                fails++; $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                  a_cnt, b_cnt, c_cnt, m_cnt[0], m_cnt[1], m_cnt[2]);
            end
            adv();
        end
    endtask

    initial begin
        clr_inputs();
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_branch();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
